// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW front end
// for a word-wide data memory; SB/SH use read-modify-write.
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   req_valid/req_ready          request handshake (stall = ~req_ready)
//   req_write, req_size,
//   req_unsigned, req_addr,
//   req_wdata                    request fields
//   rsp_valid, rsp_rdata,
//   rsp_err                      one-cycle completion pulse and result
//   mem_addr, mem_wdata,
//   mem_write, mem_read,
//   mem_rdata                    word-indexed memory port
module mem_access_unit #(
   parameter int MEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_write,
   output logic        mem_read,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RMW_WR,
      S_LRSP,
      S_SACK,
      S_ERR
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [29:0] r_idx;
   logic [1:0]  r_lane;
   logic [1:0]  r_size;
   logic        r_uns;
   logic [15:0] r_wdata;
   logic [31:0] r_word;

   logic        w_accept;
   logic        w_err;
   logic [31:0] w_merged;
   logic [31:0] w_ext;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_accept = rst_n && (r_state == S_IDLE) && req_valid;

   assign w_err = (req_size == 2'b11)
               || (req_size == 2'b01 && req_addr[0])
               || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
               || ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

   // Lane extraction for loads, from the word latched at acceptance
   assign w_byte = r_word[{r_lane, 3'b000} +: 8];
   assign w_half = r_lane[1] ? r_word[31:16] : r_word[15:0];

   always_comb begin
      w_ext = r_word;
      unique case (r_size)
         2'b00:   w_ext = {{24{w_byte[7] & ~r_uns}}, w_byte};
         2'b01:   w_ext = {{16{w_half[15] & ~r_uns}}, w_half};
         default: w_ext = r_word;
      endcase
   end

   // Sub-word store: splice captured data into the old word
   always_comb begin
      w_merged = r_word;
      if (r_size == 2'b00)
         w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
      else
         w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_lane  <= '0;
         r_size  <= '0;
         r_uns   <= 1'b0;
         r_wdata <= '0;
         r_word  <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_idx   <= req_addr[31:2];
            r_lane  <= req_addr[1:0];
            r_size  <= req_size;
            r_uns   <= req_unsigned;
            r_wdata <= req_wdata[15:0];
         end
         if (mem_read)
            r_word <= mem_rdata;
      end
   end

   always_comb begin
      w_next    = r_state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_rdata = '0;
      rsp_err   = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_write = 1'b0;
      mem_read  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (w_err) begin
                  w_next = S_ERR;
               end else if (!req_write) begin
                  mem_read = 1'b1;
                  mem_addr = {2'b00, req_addr[31:2]};
                  w_next   = S_LRSP;
               end else if (req_size == 2'b10) begin
                  mem_write = 1'b1;
                  mem_wdata = req_wdata;
                  mem_addr  = {2'b00, req_addr[31:2]};
                  w_next    = S_SACK;
               end else begin
                  mem_read = 1'b1;
                  mem_addr = {2'b00, req_addr[31:2]};
                  w_next   = S_RMW_WR;
               end
            end
         end
         S_RMW_WR: begin
            mem_write = 1'b1;
            mem_wdata = w_merged;
            mem_addr  = {2'b00, r_idx};
            w_next    = S_SACK;
         end
         S_LRSP: begin
            rsp_valid = 1'b1;
            rsp_rdata = w_ext;
            w_next    = S_IDLE;
         end
         S_SACK: begin
            rsp_valid = 1'b1;
            w_next    = S_IDLE;
         end
         S_ERR: begin
            rsp_valid = 1'b1;
            rsp_err   = 1'b1;
            w_next    = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      // Reset silences every output, including a pending RMW write
      if (!rst_n) begin
         w_next    = S_IDLE;
         req_ready = 1'b0;
         rsp_valid = 1'b0;
         rsp_rdata = '0;
         rsp_err   = 1'b0;
         mem_addr  = '0;
         mem_wdata = '0;
         mem_write = 1'b0;
         mem_read  = 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks of mem_access_unit
// against a word-array reference model kept in the bench.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_write;
   logic        mem_read;
   logic [31:0] mem_rdata;

   int checks = 0;
   int failures = 0;

   mem_access_unit #(.MEM_WORDS(1024)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_write(mem_write), .mem_read(mem_read),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Physical memory the DUT drives
   logic [31:0] phys [0:1023];
   logic        clr = 1'b1;
   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 1024; i++) phys[i] <= '0;
      end else if (mem_write) begin
         phys[mem_addr[9:0]] <= mem_wdata;
      end
   end
   assign mem_rdata = mem_read ? phys[mem_addr[9:0]] : 32'h0;

   // Reference memory
   logic [31:0] refm [0:1023];

   function automatic logic ref_err(logic [1:0] sz, logic [31:0] a);
      return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0)
          || (sz == 2'd2 && a % 4 != 0) || (a / 4 >= 1024);
   endfunction

   function automatic logic [31:0] ref_load(logic [31:0] w, logic [1:0] sz,
                                            logic uns, logic [31:0] a);
      int unsigned sh;
      longint v;
      sh = (a % 4) * 8;
      if (sz == 2'd0) begin
         v = longint'((w >> sh) & 32'hFF);
         if (!uns && v >= 128) v = v - 256;
      end else if (sz == 2'd1) begin
         v = longint'((w >> sh) & 32'hFFFF);
         if (!uns && v >= 32768) v = v - 65536;
      end else begin
         v = longint'(w);
      end
      return v[31:0];
   endfunction

   function automatic logic [31:0] ref_store(logic [31:0] old, logic [1:0] sz,
                                             logic [31:0] a, logic [31:0] d);
      int unsigned sh;
      logic [31:0] m;
      sh = (a % 4) * 8;
      if (sz == 2'd2) return d;
      m = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
      m = m << sh;
      return (old & ~m) | ((d << sh) & m);
   endfunction

   // Results of the last do_req
   logic [31:0] res_rd;
   logic        res_err;
   logic        res_rdy;
   int          res_nrd, res_nwr, res_lat, res_busy;
   logic [31:0] res_waddr, res_wdata, res_raddr;

   // Fields driven during busy cycles when hold is requested
   logic        j_write;
   logic [1:0]  j_size;
   logic [31:0] j_addr, j_wdata;

   task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic hold);
      res_rd = '0; res_err = 1'b0; res_nrd = 0; res_nwr = 0;
      res_lat = 0; res_busy = 0;
      res_waddr = '0; res_wdata = '0; res_raddr = '0;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_size = sz;
      req_unsigned = uns; req_addr = a; req_wdata = d;
      #1;
      res_rdy = req_ready;
      if (mem_read) begin res_nrd++; res_raddr = mem_addr; end
      if (mem_write) begin
         res_nwr++; res_waddr = mem_addr; res_wdata = mem_wdata;
      end
      @(posedge clk);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         res_lat++;
         if (hold) begin
            req_write = j_write; req_size = j_size;
            req_addr = j_addr; req_wdata = j_wdata;
         end else begin
            req_valid = 1'b0;
         end
         #1;
         if (!req_ready) res_busy++;
         if (mem_read) begin res_nrd++; res_raddr = mem_addr; end
         if (mem_write) begin
            res_nwr++; res_waddr = mem_addr; res_wdata = mem_wdata;
         end
         if (rsp_valid) begin
            res_rd = rsp_rdata; res_err = rsp_err;
            break;
         end
      end
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 1024; i++) refm[i] = '0;
      rst_n = 1'b0; clr = 1'b1;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({req_ready, rsp_valid, rsp_err, mem_read, mem_write} !== 5'b0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=00000",
                  {req_ready, rsp_valid, rsp_err, mem_read, mem_write});
      end
      checks++;
      if ({mem_addr, mem_wdata, rsp_rdata} !== 96'h0) begin
         failures++;
         $display("FAIL reset_data got=%h/%h/%h exp=0",
                  mem_addr, mem_wdata, rsp_rdata);
      end
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; clr = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_release got rdy=%b rsp=%b exp rdy=1 rsp=0",
                  req_ready, rsp_valid);
      end
   endtask

   task automatic test_word_store();
      do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
      refm[4] = ref_store(refm[4], 2'd2, 32'h10, 32'hDEADBEEF);
      checks++;
      if (res_nwr !== 1 || res_nrd !== 0 || res_rdy !== 1'b1) begin
         failures++;
         $display("FAIL sw_strobes got wr=%0d rd=%0d rdy=%b exp 1 0 1",
                  res_nwr, res_nrd, res_rdy);
      end
      checks++;
      if (res_waddr !== 32'd4 || res_wdata !== refm[4]) begin
         failures++;
         $display("FAIL sw_word got addr=%0d data=%h exp 4 %h",
                  res_waddr, res_wdata, refm[4]);
      end
      checks++;
      if (res_lat !== 1 || res_err !== 1'b0 || res_rd !== 32'h0) begin
         failures++;
         $display("FAIL sw_rsp got lat=%0d err=%b rd=%h exp 1 0 0",
                  res_lat, res_err, res_rd);
      end
   endtask

   task automatic test_loads();
      logic [1:0]  sz [4]  = '{2'd0, 2'd0, 2'd1, 2'd1};
      logic        un [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] ad [4]  = '{32'h13, 32'h13, 32'h12, 32'h10};
      logic [31:0] ex [4]  = '{32'hFFFFFFDE, 32'h000000DE,
                               32'hFFFFDEAD, 32'h0000BEEF};
      logic [31:0] e;
      for (int i = 0; i < 4; i++) begin
         do_req(1'b0, sz[i], un[i], ad[i], 32'h0, 1'b0);
         e = ref_load(refm[ad[i] / 4], sz[i], un[i], ad[i]);
         checks++;
         if (res_rd !== e || res_rd !== ex[i] || res_err !== 1'b0) begin
            failures++;
            $display("FAIL load_%0d got=%h err=%b exp=%h", i, res_rd,
                     res_err, ex[i]);
         end
         checks++;
         if (res_nrd !== 1 || res_nwr !== 0 || res_lat !== 1
             || res_raddr !== 32'd4) begin
            failures++;
            $display("FAIL load_seq_%0d got rd=%0d wr=%0d lat=%0d a=%0d exp 1 0 1 4",
                     i, res_nrd, res_nwr, res_lat, res_raddr);
         end
      end
   endtask

   task automatic test_rmw();
      do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h123456AA, 1'b0);
      refm[4] = ref_store(refm[4], 2'd0, 32'h11, 32'h123456AA);
      checks++;
      if (res_wdata !== refm[4] || res_wdata !== 32'hDEADAAEF
          || res_waddr !== 32'd4) begin
         failures++;
         $display("FAIL sb_merge got=%h @%0d exp=DEADAAEF @4",
                  res_wdata, res_waddr);
      end
      checks++;
      if (res_nrd !== 1 || res_nwr !== 1 || res_lat !== 2
          || res_busy !== 2 || res_err !== 1'b0) begin
         failures++;
         $display("FAIL sb_seq got rd=%0d wr=%0d lat=%0d busy=%0d err=%b exp 1 1 2 2 0",
                  res_nrd, res_nwr, res_lat, res_busy, res_err);
      end
      @(negedge clk);
      #1;
      checks++;
      if (req_ready !== 1'b1 || phys[4] !== refm[4]) begin
         failures++;
         $display("FAIL sb_after got rdy=%b mem=%h exp 1 %h",
                  req_ready, phys[4], refm[4]);
      end
   endtask

   task automatic test_errors();
      logic [1:0]  sz [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
      logic        wr [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [31:0] ad [4] = '{32'h12, 32'h13, 32'h10, 32'h1000};
      for (int i = 0; i < 4; i++) begin
         do_req(wr[i], sz[i], 1'b0, ad[i], 32'hFFFFFFFF, 1'b0);
         checks++;
         if (res_err !== 1'b1 || res_rd !== 32'h0 || res_lat !== 1) begin
            failures++;
            $display("FAIL err_%0d got err=%b rd=%h lat=%0d exp 1 0 1",
                     i, res_err, res_rd, res_lat);
         end
         checks++;
         if (res_nrd !== 0 || res_nwr !== 0) begin
            failures++;
            $display("FAIL err_strobe_%0d got rd=%0d wr=%0d exp 0 0",
                     i, res_nrd, res_nwr);
         end
      end
   endtask

   task automatic test_reset_mid_rmw();
      int stray = 0;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1;
      req_unsigned = 1'b0; req_addr = 32'h12; req_wdata = 32'h0000CAFE;
      #1;
      checks++;
      if (mem_read !== 1'b1 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL sh_issue got rd=%b rdy=%b exp 1 1", mem_read, req_ready);
      end
      @(negedge clk);
      req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (mem_write !== 1'b0 || req_ready !== 1'b0) begin
         failures++;
         $display("FAIL rst_rmw_wr got wr=%b rdy=%b exp 0 0", mem_write, req_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b1 || phys[4] !== refm[4]) begin
         failures++;
         $display("FAIL rst_rmw_after got rdy=%b mem=%h exp 1 %h",
                  req_ready, phys[4], refm[4]);
      end
      repeat (3) begin
         @(negedge clk);
         #1;
         if (rsp_valid !== 1'b0 || mem_write !== 1'b0) stray++;
      end
      checks++;
      if (stray !== 0) begin
         failures++;
         $display("FAIL rst_rmw_stray got=%0d exp=0", stray);
      end
   endtask

   task automatic test_hold_busy();
      j_write = 1'b1; j_size = 2'd2; j_addr = 32'h24; j_wdata = 32'hA5A55A5A;
      do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000BEAD, 1'b1);
      refm[4] = ref_store(refm[4], 2'd1, 32'h12, 32'h0000BEAD);
      checks++;
      if (res_nwr !== 1 || res_waddr !== 32'd4 || res_wdata !== refm[4]
          || res_lat !== 2) begin
         failures++;
         $display("FAIL hold_rmw got wr=%0d @%0d data=%h lat=%0d exp 1 @4 %h 2",
                  res_nwr, res_waddr, res_wdata, res_lat, refm[4]);
      end
      do_req(j_write, j_size, 1'b0, j_addr, j_wdata, 1'b0);
      refm[9] = ref_store(refm[9], 2'd2, j_addr, j_wdata);
      @(negedge clk);
      checks++;
      if (res_err !== 1'b0 || res_lat !== 1 || phys[9] !== refm[9]
          || phys[4] !== refm[4]) begin
         failures++;
         $display("FAIL hold_retry got err=%b lat=%0d m9=%h m4=%h exp 0 1 %h %h",
                  res_err, res_lat, phys[9], phys[4], refm[9], refm[4]);
      end
   endtask

   task automatic test_random();
      logic        w, u, e;
      logic [1:0]  sz;
      logic [31:0] a, d, exp_rd;
      int          ex_rd, ex_wr, ex_lat;
      int          bad_mem = 0;
      for (int n = 0; n < 300; n++) begin
         w  = 1'($urandom_range(0, 1));
         u  = 1'($urandom_range(0, 1));
         sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         if ($urandom_range(0, 9) == 0)
            a = 32'h1000 + 32'($urandom_range(0, 4095));
         else
            a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
         d = $urandom;
         e = ref_err(sz, a);
         exp_rd = 32'h0;
         if (e) begin
            ex_rd = 0; ex_wr = 0; ex_lat = 1;
         end else if (!w) begin
            ex_rd = 1; ex_wr = 0; ex_lat = 1;
            exp_rd = ref_load(refm[a / 4], sz, u, a);
         end else if (sz == 2'd2) begin
            ex_rd = 0; ex_wr = 1; ex_lat = 1;
         end else begin
            ex_rd = 1; ex_wr = 1; ex_lat = 2;
         end
         do_req(w, sz, u, a, d, 1'b0);
         if (!e && w) refm[a / 4] = ref_store(refm[a / 4], sz, a, d);
         checks++;
         if (res_err !== e || res_rd !== exp_rd) begin
            failures++;
            $display("FAIL rnd_%0d_rsp a=%h sz=%0d w=%b got err=%b rd=%h exp %b %h",
                     n, a, sz, w, res_err, res_rd, e, exp_rd);
         end
         checks++;
         if (res_nrd !== ex_rd || res_nwr !== ex_wr || res_lat !== ex_lat
             || res_rdy !== 1'b1) begin
            failures++;
            $display("FAIL rnd_%0d_seq got rd=%0d wr=%0d lat=%0d rdy=%b exp %0d %0d %0d 1",
                     n, res_nrd, res_nwr, res_lat, res_rdy, ex_rd, ex_wr, ex_lat);
         end
      end
      @(negedge clk);
      for (int i = 0; i < 16; i++)
         if (phys[i] !== refm[i]) bad_mem++;
      checks++;
      if (bad_mem !== 0) begin
         failures++;
         $display("FAIL rnd_mem got=%0d words differ exp=0", bad_mem);
      end
   endtask

   initial begin
      test_reset();
      test_word_store();
      test_loads();
      test_rmw();
      test_errors();
      test_reset_mid_rmw();
      test_hold_busy();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
